conv_loop_ctrl: RTL and testbench

//  Runtime-configurable loop controller for the conv accelerator; drives datapath handshakes, MAC control,

---
 rtl/conv_ctrl_pkg.sv | 22 ++
 rtl/conv_loop_counter.sv | 30 +++
 rtl/conv_loop_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_conv_loop_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_ctrl_pkg.sv
// Shared types for the conv loop controller: FSM state encoding, the latched
// run configuration and the default counter width.
package conv_ctrl_pkg;

  localparam int CONV_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } fsm_state_e;

  typedef struct packed {
    logic [CONV_CNT_W-1:0] width;
    logic [CONV_CNT_W-1:0] height;
    logic [CONV_CNT_W-1:0] ch_in;
    logic [CONV_CNT_W-1:0] ch_out;
    logic [CONV_CNT_W-1:0] kernel;
  } conv_cfg_t;

endpackage

// File: rtl/conv_loop_counter.sv
// One level of the conv loop nest. Counts 0..limit on inc_en, wraps to 0 on
// the last value and flags the wrap so the next outer level can advance.
module conv_loop_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         arst_n_in,
  input  logic         clr,
  input  logic         inc_en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         last,
  output logic         wrap
);

  assign last = (cnt == limit);
  assign wrap = inc_en && last;

  // Count register: clear at run start, advance or wrap on inc_en.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc_en) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/conv_loop_ctrl.sv
// Loop controller for the conv accelerator. Walks x > y > ch_in > ch_out group
// > k_v > k_h, one MAC step per fire, and tags outputs with their coordinates.
// Optional build macro CONV_CTRL_PERF_EN adds perf_active / perf_stall counters.
//
// Handshake: a fire happens in a cycle where a_ready, a_valid and b_valid are
// all high; a_ready drops while an output is held (out_valid && !out_ready),
// and an output is consumed in a cycle where out_valid && out_ready.
module conv_loop_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int LOG2_OF_MEM_HEIGHT = 20,
  parameter int CNT_W              = CONV_CNT_W,
  parameter int MAX_KERNEL_SIZE    = 7,
  parameter int OUT_PAR            = 4
) (
  input  logic                          clk,
  input  logic                          arst_n_in,
  input  logic                          start,
  input  logic [CNT_W-1:0]              cfg_width,
  input  logic [CNT_W-1:0]              cfg_height,
  input  logic [CNT_W-1:0]              cfg_ch_in,
  input  logic [CNT_W-1:0]              cfg_ch_out,
  input  logic [CNT_W-1:0]              cfg_kernel,
  output logic                          running,
  output logic                          done,
  output logic                          cfg_err,
  input  logic                          a_valid,
  input  logic                          b_valid,
  output logic                          a_ready,
  output logic                          b_ready,
  output logic                          write_a,
  output logic                          write_b,
  output logic                          mac_valid,
  output logic                          mac_accumulate_internal,
  output logic                          mac_accumulate_with_0,
  output logic                          mem_re,
  output logic [LOG2_OF_MEM_HEIGHT-1:0] mem_read_addr,
  output logic                          mem_we,
  output logic [LOG2_OF_MEM_HEIGHT-1:0] mem_write_addr,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CNT_W-1:0]              out_x,
  output logic [CNT_W-1:0]              out_y,
  output logic [CNT_W-1:0]              out_ch,
  output logic [OUT_PAR-1:0]            out_ch_mask,
  output logic [1:0]                    state_dbg
`ifdef CONV_CTRL_PERF_EN
  ,
  output logic [31:0]                   perf_active,
  output logic [31:0]                   perf_stall
`endif
);

  // Loop levels, innermost first.
  localparam int L_KH = 0, L_KV = 1, L_GRP = 2, L_CIN = 3, L_Y = 4, L_X = 5;

  fsm_state_e state, state_nxt;
  conv_cfg_t  cfg_q;

  logic             stall, fire, tap0, last_tap, launch, cfg_bad;
  logic [CNT_W-1:0] cnt   [6];
  logic [CNT_W-1:0] limit [6];
  logic [5:0]       last, wrap, inc;
  logic [CNT_W:0]   num_grp;
  logic [CNT_W-1:0] out_ch_nxt;
  logic [OUT_PAR-1:0] mask_nxt;

  assign launch  = (state == IDLE) && start;
  assign stall   = out_valid && !out_ready;
  assign a_ready = (state == RUN) && !stall;
  assign b_ready = a_ready;
  assign fire    = a_ready && a_valid && b_valid;
  assign write_a = fire;
  assign write_b = fire;
  assign mac_valid = fire;
  assign running   = (state != IDLE);
  assign state_dbg = state;

  assign tap0     = (cnt[L_KV] == '0) && (cnt[L_KH] == '0);
  assign last_tap = last[L_KV] && last[L_KH];

  assign mac_accumulate_internal = fire && !tap0;
  assign mac_accumulate_with_0   = fire && tap0 && (cnt[L_CIN] == '0);
  assign mem_re        = fire && tap0 && (cnt[L_CIN] != '0);
  assign mem_read_addr = LOG2_OF_MEM_HEIGHT'(cnt[L_GRP]);

  assign cfg_bad = (cfg_q.width == '0) || (cfg_q.height == '0) ||
                   (cfg_q.ch_in == '0) || (cfg_q.ch_out == '0) ||
                   (cfg_q.kernel == '0) ||
                   (cfg_q.kernel > CNT_W'(MAX_KERNEL_SIZE));

  // Number of output-channel groups, rounded up.
  assign num_grp = ({1'b0, cfg_q.ch_out} + (CNT_W+1)'(OUT_PAR - 1)) /
                   (CNT_W+1)'(OUT_PAR);

  assign limit[L_KH]  = cfg_q.kernel - 1'b1;
  assign limit[L_KV]  = cfg_q.kernel - 1'b1;
  assign limit[L_GRP] = CNT_W'(num_grp - 1'b1);
  assign limit[L_CIN] = cfg_q.ch_in - 1'b1;
  assign limit[L_Y]   = cfg_q.height - 1'b1;
  assign limit[L_X]   = cfg_q.width - 1'b1;

  assign inc[0] = fire;
  assign inc[5:1] = wrap[4:0];

  for (genvar i = 0; i < 6; i++) begin : g_lvl
    conv_loop_counter #(.W(CNT_W)) u_cnt (
      .clk       (clk),
      .arst_n_in (arst_n_in),
      .clr       (launch),
      .inc_en    (inc[i]),
      .limit     (limit[i]),
      .cnt       (cnt[i]),
      .last      (last[i]),
      .wrap      (wrap[i])
    );
  end

  assign out_ch_nxt = CNT_W'(cnt[L_GRP] * OUT_PAR);

  // Lane mask for the group being emitted: lanes past cfg_ch_out are off.
  always_comb begin
    mask_nxt = '0;
    for (int i = 0; i < OUT_PAR; i++) begin
      mask_nxt[i] = (({1'b0, out_ch_nxt} + (CNT_W+1)'(i)) < {1'b0, cfg_q.ch_out});
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) state <= IDLE;
    else            state <= state_nxt;
  end

  // FSM next-state: the x-level wrap marks the final MAC step of the run.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CHECK;
      CHECK:   state_nxt = cfg_bad ? IDLE : RUN;
      RUN:     if (wrap[L_X]) state_nxt = DRAIN;
      DRAIN:   if (!out_valid || out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Config latch, status flags, partial-sum write strobe and output tagging.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      cfg_q          <= '0;
      cfg_err        <= 1'b0;
      done           <= 1'b0;
      mem_we         <= 1'b0;
      mem_write_addr <= '0;
      out_valid      <= 1'b0;
      out_x          <= '0;
      out_y          <= '0;
      out_ch         <= '0;
      out_ch_mask    <= '0;
    end else begin
      done   <= (state == DRAIN) && (!out_valid || out_ready);
      mem_we <= fire && last_tap && !last[L_CIN];
      if (launch) begin
        cfg_q   <= '{width: cfg_width, height: cfg_height, ch_in: cfg_ch_in,
                     ch_out: cfg_ch_out, kernel: cfg_kernel};
        cfg_err <= 1'b0;
      end
      if ((state == CHECK) && cfg_bad) cfg_err <= 1'b1;
      if (fire && last_tap && !last[L_CIN]) begin
        mem_write_addr <= LOG2_OF_MEM_HEIGHT'(cnt[L_GRP]);
      end
      if (fire && last_tap && last[L_CIN]) begin
        out_valid   <= 1'b1;
        out_x       <= cnt[L_X];
        out_y       <= cnt[L_Y];
        out_ch      <= out_ch_nxt;
        out_ch_mask <= mask_nxt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef CONV_CTRL_PERF_EN
  // Saturating activity counters, cleared when a run is launched.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      perf_active <= '0;
      perf_stall  <= '0;
    end else if (launch) begin
      perf_active <= '0;
      perf_stall  <= '0;
    end else begin
      if (fire && (perf_active != '1)) perf_active <= perf_active + 1'b1;
      if ((state == RUN) && !fire && (perf_stall != '1)) perf_stall <= perf_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_loop_ctrl.sv
// Directed bench for conv_loop_ctrl: a loop-nest model fills scoreboard queues
// (per-fire MAC control, partial-sum writes, tagged outputs) and a negedge
// monitor pops and compares them as the DUT produces events.
module tb_conv_loop_ctrl;

  localparam int CNT_W   = 16;
  localparam int LOG2    = 20;
  localparam int OUT_PAR = 4;
  localparam int OW      = 3 * CNT_W + OUT_PAR;
  localparam int FW      = 3 + LOG2;

  logic clk = 1'b0;
  logic arst_n_in = 1'b1;
  logic start = 1'b0;
  logic [CNT_W-1:0] cfg_width = '0, cfg_height = '0, cfg_ch_in = '0;
  logic [CNT_W-1:0] cfg_ch_out = '0, cfg_kernel = '0;
  logic running, done, cfg_err;
  logic a_valid = 1'b1, b_valid = 1'b1;
  logic a_ready, b_ready, write_a, write_b, mac_valid;
  logic mac_accumulate_internal, mac_accumulate_with_0;
  logic mem_re, mem_we;
  logic [LOG2-1:0] mem_read_addr, mem_write_addr;
  logic out_valid, out_ready = 1'b1;
  logic [CNT_W-1:0] out_x, out_y, out_ch;
  logic [OUT_PAR-1:0] out_ch_mask;
  logic [1:0] state_dbg;
`ifdef CONV_CTRL_PERF_EN
  logic [31:0] perf_active, perf_stall;
`endif

  conv_loop_ctrl #(
    .LOG2_OF_MEM_HEIGHT(LOG2), .CNT_W(CNT_W), .MAX_KERNEL_SIZE(7), .OUT_PAR(OUT_PAR)
  ) dut (
    .clk(clk), .arst_n_in(arst_n_in), .start(start),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_ch_in(cfg_ch_in),
    .cfg_ch_out(cfg_ch_out), .cfg_kernel(cfg_kernel),
    .running(running), .done(done), .cfg_err(cfg_err),
    .a_valid(a_valid), .b_valid(b_valid), .a_ready(a_ready), .b_ready(b_ready),
    .write_a(write_a), .write_b(write_b), .mac_valid(mac_valid),
    .mac_accumulate_internal(mac_accumulate_internal),
    .mac_accumulate_with_0(mac_accumulate_with_0),
    .mem_re(mem_re), .mem_read_addr(mem_read_addr),
    .mem_we(mem_we), .mem_write_addr(mem_write_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_ch(out_ch), .out_ch_mask(out_ch_mask),
    .state_dbg(state_dbg)
`ifdef CONV_CTRL_PERF_EN
    , .perf_active(perf_active), .perf_stall(perf_stall)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int fire_cnt = 0;
  int done_cnt = 0;
  int last_acc_cyc = -1;
  int done_cyc = -2;
  logic [OW-1:0]   exp_q[$];
  logic [FW-1:0]   fire_q[$];
  logic [LOG2-1:0] we_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [FW-1:0]   fe;
    logic [OW-1:0]   oe;
    logic [LOG2-1:0] we;
    cyc++;
    if (arst_n_in) begin
      check("fire_strobes", {mac_valid, write_a, write_b, b_ready, mem_re & ~mac_valid},
            {{3{a_ready && a_valid && b_valid}}, a_ready, 1'b0});
      if (mac_valid) begin
        fire_cnt++;
        check("fire_q_nonempty", 64'(fire_q.size() > 0), 64'd1);
        if (fire_q.size() > 0) begin
          fe = fire_q.pop_front();
          check("fire_ctrl", {mac_accumulate_internal, mac_accumulate_with_0, mem_re, mem_read_addr}, fe);
        end
      end
      if (mem_we) begin
        check("we_q_nonempty", 64'(we_q.size() > 0), 64'd1);
        if (we_q.size() > 0) begin
          we = we_q.pop_front();
          check("mem_write_addr", mem_write_addr, we);
        end
      end
      if (out_valid && out_ready) begin
        last_acc_cyc = cyc;
        check("out_q_nonempty", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          oe = exp_q.pop_front();
          check("out_tag", {out_x, out_y, out_ch, out_ch_mask}, oe);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- driver / model tasks ----------------
  task automatic push_model(input int w, input int h, input int cin, input int cout,
                            input int k, output int n_fire);
    int ng;
    logic [OUT_PAR-1:0] m;
    logic t0;
    ng = (cout + OUT_PAR - 1) / OUT_PAR;
    n_fire = 0;
    for (int x = 0; x < w; x++)
      for (int y = 0; y < h; y++)
        for (int ci = 0; ci < cin; ci++)
          for (int g = 0; g < ng; g++)
            for (int kv = 0; kv < k; kv++)
              for (int kh = 0; kh < k; kh++) begin
                t0 = (kv == 0) && (kh == 0);
                fire_q.push_back({!t0, t0 && (ci == 0), t0 && (ci != 0), LOG2'(g)});
                n_fire++;
                if ((kv == k - 1) && (kh == k - 1)) begin
                  if (ci == cin - 1) begin
                    for (int i = 0; i < OUT_PAR; i++) m[i] = (g * OUT_PAR + i) < cout;
                    exp_q.push_back({CNT_W'(x), CNT_W'(y), CNT_W'(g * OUT_PAR), m});
                  end else begin
                    we_q.push_back(LOG2'(g));
                  end
                end
              end
  endtask

  task automatic reset_counters();
    fire_cnt = 0;
    done_cnt = 0;
    last_acc_cyc = -1;
    done_cyc = -2;
  endtask

  // Called aligned to posedge+#1; returns one cycle later with start low.
  task automatic start_run(input int w, input int h, input int cin, input int cout, input int k);
    cfg_width  = CNT_W'(w);
    cfg_height = CNT_W'(h);
    cfg_ch_in  = CNT_W'(cin);
    cfg_ch_out = CNT_W'(cout);
    cfg_kernel = CNT_W'(k);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic finish_run(input int exp_fires, input int budget, input bit rnd);
    for (int i = 0; i < budget && done_cnt == 0; i++) begin
      @(posedge clk); #1;
      if (rnd) begin
        a_valid = 1'($urandom_range(0, 1));
        b_valid = 1'($urandom_range(0, 1));
      end
    end
    a_valid = 1'b1;
    b_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", done_cnt, 1);
    check("fire_count", fire_cnt, exp_fires);
    check("out_q_left", exp_q.size(), 0);
    check("fire_q_left", fire_q.size(), 0);
    check("we_q_left", we_q.size(), 0);
    check("done_after_accept", done_cyc, last_acc_cyc + 1);
    check("idle_after_done", {running, state_dbg}, 3'b000);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {running, done, cfg_err, a_ready, b_ready, write_a, write_b, mac_valid,
                mac_accumulate_internal, mac_accumulate_with_0, mem_re, mem_we, out_valid,
                state_dbg, mem_read_addr, mem_write_addr}, 64'd0);
    check({tag, "_tags"}, {out_x, out_y, out_ch, out_ch_mask}, 64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int nf;

    // Reset
    #2 arst_n_in = 1'b0;
    #5 check_all_zero("reset_outputs");
    repeat (2) @(posedge clk);
    #1 arst_n_in = 1'b1;
    @(posedge clk); #1;

    // 1: 2x2, Cin=1, Cout=4, K=1: one output per fire, no partial-sum traffic
    reset_counters();
    push_model(2, 2, 1, 4, 1, nf);
    start_run(2, 2, 1, 4, 1);
    finish_run(nf, 200, 1'b0);
`ifdef CONV_CTRL_PERF_EN
    check("perf_active", perf_active, 32'd4);
`endif

    // 2: 1x1, Cin=2, Cout=8, K=3 with random operand valids
    reset_counters();
    push_model(1, 1, 2, 8, 3, nf);
    check("model_fires_t2", nf, 36);
    start_run(1, 1, 2, 8, 3);
    finish_run(nf, 1000, 1'b1);

    // 3: Cout=6 -> partial second group, K=2
    reset_counters();
    push_model(1, 1, 1, 6, 2, nf);
    start_run(1, 1, 1, 6, 2);
    finish_run(nf, 200, 1'b0);

    // 4: output backpressure holds the first output for 10 cycles
    reset_counters();
    out_ready = 1'b0;
    push_model(2, 2, 1, 4, 1, nf);
    start_run(2, 2, 1, 4, 1);
    for (int i = 0; i < 20 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    check("bp_out_valid_seen", out_valid, 1'b1);
    begin
      int f0;
      f0 = fire_cnt;
      repeat (10) begin
        @(negedge clk);
        check("bp_a_ready_low", {a_ready, out_valid}, 2'b01);
        check("bp_out_stable", {out_x, out_y, out_ch, out_ch_mask}, exp_q[0]);
      end
      check("bp_no_fires", fire_cnt, f0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_resume", a_ready, 1'b1);
    @(posedge clk); #1;
    finish_run(nf, 200, 1'b0);

    // 5: illegal configs: kernel above max, then zero input channels
    reset_counters();
    start_run(1, 1, 1, 4, 8);
    check("bad_k_running_in_check", {running, cfg_err}, 2'b10);
    @(posedge clk); #1;
    check("bad_k_err", {running, cfg_err}, 2'b01);
    reset_counters();
    start_run(2, 2, 0, 4, 1);
    check("bad_cin_err_cleared_on_start", {running, cfg_err}, 2'b10);
    @(posedge clk); #1;
    check("bad_cin_err", {running, cfg_err}, 2'b01);
    repeat (3) @(posedge clk);
    #1;
    check("bad_cfg_no_fire", fire_cnt, 0);
    check("bad_cfg_no_done", done_cnt, 0);

    // Legal run after an error clears cfg_err
    reset_counters();
    push_model(1, 1, 1, 6, 2, nf);
    start_run(1, 1, 1, 6, 2);
    check("err_cleared", cfg_err, 1'b0);
    finish_run(nf, 200, 1'b0);

    // 6: asynchronous reset mid-run, then a clean rerun of test 1
    reset_counters();
    push_model(2, 2, 1, 4, 1, nf);
    start_run(2, 2, 1, 4, 1);
    repeat (2) @(posedge clk);
    #1 arst_n_in = 1'b0;
    #1 check_all_zero("midrun_reset");
    exp_q.delete();
    fire_q.delete();
    we_q.delete();
    @(posedge clk); #1;
    check("reset_no_done", done_cnt, 0);
    arst_n_in = 1'b1;
    @(posedge clk); #1;
    reset_counters();
    push_model(2, 2, 1, 4, 1, nf);
    start_run(2, 2, 1, 4, 1);
    finish_run(nf, 200, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
